dcache_miss_ctrl: RTL and testbench

- MEM-stage data-cache controller, directly upstream of the MEM/WB pipeline register.
- Serves load/store hits from an external direct-mapped data array and tag array.
- On a miss, runs an 8-word block fill from shared multi-cycle main memory (write-allocate); stores are write-through.
- Drives the load word into MEM/WB Mem_DataIn and raises a stall that freezes the earlier stages; MEM/WB loads a bubble while stalled.

---
 rtl/dcache_miss_ctrl.sv | 145 ++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - MEM-stage data-cache controller with 8-word block fill
module dcache_miss_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [15:0] Addr_In,
  input  logic [15:0] WData_In,
  input  logic        Hit_In,
  input  logic [15:0] CacheData_In,
  input  logic        MemGrant_In,
  input  logic        MemDataValid_In,
  input  logic [15:0] MemRData_In,
  output logic        Stall_Out,
  output logic [15:0] Mem_DataOut,
  output logic        TagWrite_Out,
  output logic        DataWrite_Out,
  output logic [2:0]  CacheWordSel_Out,
  output logic [15:0] CacheWData_Out,
  output logic        MemEnable_Out,
  output logic        MemWr_Out,
  output logic [15:0] MemAddr_Out,
  output logic [15:0] MemWData_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TAGWR = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ic;
  logic [3:0]  rc;
  logic [11:0] base_tag;

  logic access;
  logic miss;
  logic issue;
  logic recv;

  // A simultaneous read and write is handled as a store: MemWrite_In alone selects the store path.
  assign access = MemRead_In | MemWrite_In;
  assign miss   = access & ~Hit_In;
  assign issue  = (state == FILL) & MemGrant_In & (ic < 4'd8);
  assign recv   = (state == FILL) & MemDataValid_In;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill bookkeeping: issue/receive counters and the block base latched at miss time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic       <= 4'd0;
      rc       <= 4'd0;
      base_tag <= 12'd0;
    end else if (state == IDLE && miss) begin
      ic       <= 4'd0;
      rc       <= 4'd0;
      base_tag <= Addr_In[15:4];
    end else begin
      if (issue) begin
        ic <= ic + 4'd1;
      end
      if (recv && rc < 4'd8) begin
        rc <= rc + 4'd1;
      end
    end
  end

  // Next-state logic: the eighth returned word ends the fill
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss) state_nxt = FILL;
      FILL:    if (recv && rc == 4'd7) state_nxt = TAGWR;
      TAGWR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; everything except the word select is held at zero while reset is asserted
  always_comb begin
    Stall_Out        = 1'b0;
    Mem_DataOut      = 16'd0;
    TagWrite_Out     = 1'b0;
    DataWrite_Out    = 1'b0;
    CacheWordSel_Out = Addr_In[3:1];
    CacheWData_Out   = 16'd0;
    MemEnable_Out    = 1'b0;
    MemWr_Out        = 1'b0;
    MemAddr_Out      = 16'd0;
    MemWData_Out     = 16'd0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (miss) begin
            Stall_Out = 1'b1;
          end else if (access && MemWrite_In) begin
            // Write-through store: array and memory are written together, or neither is.
            if (MemGrant_In) begin
              DataWrite_Out  = 1'b1;
              CacheWData_Out = WData_In;
              MemEnable_Out  = 1'b1;
              MemWr_Out      = 1'b1;
              MemAddr_Out    = Addr_In;
              MemWData_Out   = WData_In;
            end else begin
              Stall_Out = 1'b1;
            end
          end else if (access) begin
            Mem_DataOut = CacheData_In;
          end
        end
        FILL: begin
          Stall_Out = 1'b1;
          if (issue) begin
            MemEnable_Out = 1'b1;
            MemAddr_Out   = {base_tag, ic[2:0], 1'b0};
          end
          if (recv) begin
            DataWrite_Out    = 1'b1;
            CacheWordSel_Out = rc[2:0];
            CacheWData_Out   = MemRData_In;
          end
        end
        TAGWR: begin
          Stall_Out    = 1'b1;
          TagWrite_Out = 1'b1;
        end
        default: begin
          Stall_Out = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - randomized self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;
  localparam int MEM_LATENCY     = 4;
  localparam int WORDS_PER_BLOCK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_In, MemWrite_In, Hit_In, MemGrant_In, MemDataValid_In;
  logic [15:0] Addr_In, WData_In, CacheData_In, MemRData_In;
  logic        Stall_Out, TagWrite_Out, DataWrite_Out, MemEnable_Out, MemWr_Out;
  logic [15:0] Mem_DataOut, CacheWData_Out, MemAddr_Out, MemWData_Out;
  logic [2:0]  CacheWordSel_Out;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .Addr_In(Addr_In), .WData_In(WData_In),
    .Hit_In(Hit_In), .CacheData_In(CacheData_In), .MemGrant_In(MemGrant_In),
    .MemDataValid_In(MemDataValid_In), .MemRData_In(MemRData_In),
    .Stall_Out(Stall_Out), .Mem_DataOut(Mem_DataOut), .TagWrite_Out(TagWrite_Out),
    .DataWrite_Out(DataWrite_Out), .CacheWordSel_Out(CacheWordSel_Out), .CacheWData_Out(CacheWData_Out),
    .MemEnable_Out(MemEnable_Out), .MemWr_Out(MemWr_Out), .MemAddr_Out(MemAddr_Out), .MemWData_Out(MemWData_Out)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
  } mreq_t;

  // Main memory, outstanding reads, and the external tag/data arrays (8 sets, index Addr[6:4])
  mreq_t       mq[$];
  logic [15:0] mem_arr [0:32767];
  logic [11:0] ttag [0:7];
  bit          tvalid [0:7];
  logic [15:0] cdata [0:7][0:7];

  // Transaction-level model: addresses still to request, words still to receive, tag write owed
  logic [15:0] m_issue_q[$];
  int          m_recv_left, m_recv_idx;
  bit          m_tag_pending;

  int n_checks, n_errors, cyc;
  bit rand_grant, noise_en;
  int drop_left, drop_at;

  int          iss_cyc[$], dw_cyc[$], dw_sel[$], tw_cyc[$], mw_cyc[$];
  logic [15:0] iss_addr[$], mw_addr[$], mw_data[$];
  int          stall_cnt, access_cycles;
  bit          last_stall;
  logic [15:0] last_dout;
  logic        a_stall, a_tw, a_dw, a_en, a_wr;
  logic [2:0]  a_sel;
  logic [15:0] a_dout, a_cwd, a_maddr, a_mwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic log_clear();
    iss_cyc.delete(); iss_addr.delete(); dw_cyc.delete(); dw_sel.delete();
    tw_cyc.delete(); mw_cyc.delete(); mw_addr.delete(); mw_data.delete();
    stall_cnt = 0;
  endtask

  // One clock: drive memory/array inputs, compare every output to the model, then advance everything
  task automatic cycle();
    bit          noise, grant_v, valid_v, rst_v, acc_v, hit_v;
    logic [2:0]  set;
    logic [15:0] rdata_v, addr_v, ra;
    bit          e_stall, e_tw, e_dw, e_en, e_wr;
    logic [2:0]  e_sel;
    logic [15:0] e_dout, e_cwd, e_maddr, e_mwd;
    mreq_t       r;
    if (drop_left > 0) begin
      MemGrant_In = 1'b0;
      drop_left--;
    end else begin
      MemGrant_In = rand_grant ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    noise = 1'b0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      ra = mq[0].addr;
      MemDataValid_In = 1'b1;
      MemRData_In = mem_arr[ra[15:1]];
    end else if (noise_en && m_recv_left == 0 && mq.size() == 0 && $urandom_range(0, 4) == 0) begin
      MemDataValid_In = 1'b1;
      MemRData_In = 16'($urandom);
      noise = 1'b1;
    end else begin
      MemDataValid_In = 1'b0;
      MemRData_In = 16'($urandom);
    end
    set = Addr_In[6:4];
    Hit_In = tvalid[set] && (ttag[set] == Addr_In[15:4]);
    CacheData_In = cdata[set][Addr_In[3:1]];
    #3;
    rst_v = rst; grant_v = MemGrant_In; valid_v = MemDataValid_In; rdata_v = MemRData_In;
    acc_v = MemRead_In || MemWrite_In; hit_v = Hit_In; addr_v = Addr_In;

    e_stall = 0; e_tw = 0; e_dw = 0; e_en = 0; e_wr = 0;
    e_sel = Addr_In[3:1]; e_dout = 0; e_cwd = 0; e_maddr = 0; e_mwd = 0;
    if (rst_v) begin
      if (m_tag_pending) begin
        e_stall = 1; e_tw = 1;
      end else if (m_recv_left > 0) begin
        e_stall = 1;
        if (grant_v && m_issue_q.size() > 0) begin
          e_en = 1; e_maddr = m_issue_q[0];
        end
        if (valid_v) begin
          e_dw = 1; e_sel = m_recv_idx[2:0]; e_cwd = rdata_v;
        end
      end else if (acc_v) begin
        if (!hit_v) e_stall = 1;
        else if (MemWrite_In) begin
          if (grant_v) begin
            e_dw = 1; e_cwd = WData_In; e_en = 1; e_wr = 1; e_maddr = Addr_In; e_mwd = WData_In;
          end else begin
            e_stall = 1;
          end
        end else begin
          e_dout = CacheData_In;
        end
      end
    end

    a_stall = Stall_Out; a_tw = TagWrite_Out; a_dw = DataWrite_Out; a_en = MemEnable_Out; a_wr = MemWr_Out;
    a_sel = CacheWordSel_Out; a_dout = Mem_DataOut; a_cwd = CacheWData_Out; a_maddr = MemAddr_Out; a_mwd = MemWData_Out;
    chk("Stall_Out", a_stall, e_stall);
    chk("Mem_DataOut", a_dout, e_dout);
    chk("TagWrite_Out", a_tw, e_tw);
    chk("DataWrite_Out", a_dw, e_dw);
    chk("CacheWordSel_Out", a_sel, e_sel);
    chk("CacheWData_Out", a_cwd, e_cwd);
    chk("MemEnable_Out", a_en, e_en);
    chk("MemWr_Out", a_wr, e_wr);
    chk("MemAddr_Out", a_maddr, e_maddr);
    chk("MemWData_Out", a_mwd, e_mwd);

    @(posedge clk);
    #1;
    if (a_dw) begin
      cdata[set][a_sel] = a_cwd;
      dw_cyc.push_back(cyc); dw_sel.push_back(int'(a_sel));
    end
    if (a_tw) begin
      ttag[set] = addr_v[15:4]; tvalid[set] = 1'b1;
      tw_cyc.push_back(cyc);
    end
    if (a_en && grant_v) begin
      if (a_wr) begin
        mem_arr[a_maddr[15:1]] = a_mwd;
        mw_cyc.push_back(cyc); mw_addr.push_back(a_maddr); mw_data.push_back(a_mwd);
      end else begin
        r.due = cyc + MEM_LATENCY; r.addr = a_maddr;
        mq.push_back(r);
        iss_cyc.push_back(cyc); iss_addr.push_back(a_maddr);
        if (iss_cyc.size() == drop_at) begin
          drop_left = 3; drop_at = -1;
        end
      end
    end
    if (valid_v && !noise) void'(mq.pop_front());
    if (a_stall) stall_cnt++;

    if (!rst_v) begin
      m_issue_q.delete(); m_recv_left = 0; m_recv_idx = 0; m_tag_pending = 0;
    end else if (m_tag_pending) begin
      m_tag_pending = 0;
    end else if (m_recv_left > 0) begin
      if (grant_v && m_issue_q.size() > 0) void'(m_issue_q.pop_front());
      if (valid_v) begin
        m_recv_idx++; m_recv_left--;
        if (m_recv_left == 0) m_tag_pending = 1;
      end
    end else if (acc_v && !hit_v) begin
      m_issue_q.delete();
      for (int i = 0; i < WORDS_PER_BLOCK; i++) m_issue_q.push_back({addr_v[15:4], 4'd0} + 16'(2 * i));
      m_recv_idx = 0; m_recv_left = WORDS_PER_BLOCK;
    end
    last_stall = e_stall;
    last_dout = a_dout;
    cyc++;
  endtask

  task automatic idle(input int n);
    MemRead_In = 0; MemWrite_In = 0;
    for (int i = 0; i < n; i++) begin
      Addr_In = 16'($urandom);
      cycle();
    end
  endtask

  // Hold one access stable until the model says it completes; loads must return memory's value
  task automatic do_access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    int n;
    n = 0;
    MemRead_In = rd; MemWrite_In = wr; Addr_In = a; WData_In = wd;
    do begin
      cycle(); n++;
    end while (last_stall && n < 80);
    chk("access_done", last_stall, 0);
    if (rd && !wr) chk("load_vs_memory", last_dout, mem_arr[a[15:1]]);
    access_cycles = n;
    MemRead_In = 0; MemWrite_In = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, n;
    logic [15:0] a;
    n_checks = 0; n_errors = 0; cyc = 0;
    rand_grant = 0; noise_en = 0; drop_left = 0; drop_at = -1;
    m_recv_left = 0; m_recv_idx = 0; m_tag_pending = 0;
    for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);
    for (int s = 0; s < 8; s++) begin
      tvalid[s] = 0; ttag[s] = 0;
      for (int w = 0; w < 8; w++) cdata[s][w] = 0;
    end
    rst = 0; MemRead_In = 0; MemWrite_In = 0; Addr_In = 16'h1236; WData_In = 0;
    Hit_In = 0; CacheData_In = 0; MemGrant_In = 0; MemDataValid_In = 0; MemRData_In = 0;
    @(posedge clk); #1;
    log_clear();
    idle(2);
    chk("reset_no_activity", stall_cnt + dw_cyc.size() + iss_cyc.size(), 0);
    rst = 1;
    idle(2);

    // Load hit at 0x1236 returning 0xBEEF
    a = 16'h1230;
    for (int w = 0; w < 8; w++) cdata[3][w] = mem_arr[a[15:1] + 15'(w)];
    a = 16'h1236;
    mem_arr[a[15:1]] = 16'hBEEF; cdata[3][3] = 16'hBEEF; ttag[3] = 12'h123; tvalid[3] = 1;
    log_clear();
    do_access(1, 0, 16'h1236, 16'h0);
    chk("hit_data", last_dout, 16'hBEEF);
    chk("hit_sel", a_sel, 3);
    chk("hit_cycles", access_cycles, 1);
    chk("hit_no_mem", iss_cyc.size() + mw_cyc.size(), 0);

    // Load miss at 0x2A4C, memory word i holds 0x1000+i, grant always high
    a = 16'h2A40;
    for (int w = 0; w < 8; w++) mem_arr[a[15:1] + 15'(w)] = 16'h1000 + 16'(w);
    log_clear(); t0 = cyc;
    do_access(1, 0, 16'h2A4C, 16'h0);
    chk("miss_issues", iss_cyc.size(), 8);
    chk("miss_writes", dw_cyc.size(), 8);
    if (iss_cyc.size() == 8 && dw_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("miss_issue_cyc", iss_cyc[i], t0 + 1 + i);
        chk("miss_issue_addr", iss_addr[i], 16'h2A40 + 16'(2 * i));
        chk("miss_dw_cyc", dw_cyc[i], t0 + 5 + i);
        chk("miss_dw_sel", dw_sel[i], i);
      end
    end
    chk("miss_tagwr_count", tw_cyc.size(), 1);
    if (tw_cyc.size() == 1) chk("miss_tagwr_cyc", tw_cyc[0], t0 + 13);
    chk("miss_stall_cycles", stall_cnt, 14);
    chk("miss_replay_data", last_dout, 16'h1006);

    // Grant dropped for three cycles right after the second issue
    log_clear(); t0 = cyc; drop_at = 2;
    do_access(1, 0, 16'h0156, 16'h0);
    chk("drop_issues", iss_cyc.size(), 8);
    if (iss_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("drop_issue_cyc", iss_cyc[i], t0 + 1 + i + (i >= 2 ? 3 : 0));
        chk("drop_issue_addr", iss_addr[i], 16'h0150 + 16'(2 * i));
      end
    end
    if (tw_cyc.size() == 1) chk("drop_tagwr_cyc", tw_cyc[0], t0 + 16);
    chk("drop_tagwr_count", tw_cyc.size(), 1);

    // Store hit 0x0010 <- 0x55AA with grant low for two cycles
    do_access(1, 0, 16'h0010, 16'h0);
    log_clear(); t0 = cyc; drop_left = 2;
    do_access(0, 1, 16'h0010, 16'h55AA);
    chk("st_stall_cycles", stall_cnt, 2);
    chk("st_cycles", access_cycles, 3);
    chk("st_dw_count", dw_cyc.size(), 1);
    chk("st_mw_count", mw_cyc.size(), 1);
    if (mw_cyc.size() == 1) begin
      chk("st_mw_cyc", mw_cyc[0], t0 + 2);
      chk("st_mw_addr", mw_addr[0], 16'h0010);
      chk("st_mw_data", mw_data[0], 16'h55AA);
    end
    do_access(1, 0, 16'h0010, 16'h0);
    chk("st_readback", last_dout, 16'h55AA);

    // Store miss: full fill, then exactly one write-through after the tag write
    log_clear();
    do_access(0, 1, 16'h0E22, 16'h1234);
    chk("stm_issues", iss_cyc.size(), 8);
    chk("stm_dw_count", dw_cyc.size(), 9);
    chk("stm_mw_count", mw_cyc.size(), 1);
    chk("stm_stall_cycles", stall_cnt, 14);
    if (mw_cyc.size() == 1 && tw_cyc.size() == 1) begin
      chk("stm_mw_after_tag", mw_cyc[0], tw_cyc[0] + 1);
      chk("stm_mw_addr", mw_addr[0], 16'h0E22);
    end
    do_access(1, 0, 16'h0E22, 16'h0);
    chk("stm_readback", last_dout, 16'h1234);

    // Reset pulsed after four words of a fill have been written
    log_clear();
    MemRead_In = 1; MemWrite_In = 0; Addr_In = 16'h7770;
    n = 0;
    while (dw_cyc.size() < 4 && n < 40) begin
      cycle(); n++;
    end
    chk("rst_four_words", dw_cyc.size(), 4);
    rst = 0; MemRead_In = 0;
    cycle();
    chk("rst_outputs_zero", {a_stall, a_tw, a_dw, a_en, a_wr}, 0);
    rst = 1;
    idle(12);
    chk("rst_no_tagwr", tw_cyc.size(), 0);
    chk("rst_no_more_dw", dw_cyc.size(), 4);
    chk("rst_block_invalid", tvalid[7], 0);
    chk("rst_mem_drained", mq.size(), 0);

    // Randomized traffic with intermittent grant and stray valids while idle
    rand_grant = 1; noise_en = 1;
    for (int k = 0; k < 250; k++) begin
      int op;
      idle($urandom_range(0, 2));
      a = {6'd0, 2'($urandom_range(0, 2)), 8'($urandom)};
      op = $urandom_range(0, 7);
      if (op < 4) do_access(1, 0, a, 16'h0);
      else if (op < 7) do_access(0, 1, a, 16'($urandom));
      else do_access(1, 1, a, 16'($urandom));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
